// File: rtl/cory_rrmux4.sv
// Four-input round-robin merge with a single registered output slot and a 2-bit source tag.
// Define CORY_RRMUX4_LAST_EN to add end-of-packet ports and hold the grant for whole packets.
module cory_rrmux4 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  output logic         o_a1_r,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  output logic         o_a2_r,
  input  logic         i_a3_v,
  input  logic [N-1:0] i_a3_d,
  output logic         o_a3_r,
`ifdef CORY_RRMUX4_LAST_EN
  input  logic         i_a0_l,
  input  logic         i_a1_l,
  input  logic         i_a2_l,
  input  logic         i_a3_l,
  output logic         o_z_l,
`endif
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic [1:0]   o_z_s,
  input  logic         i_z_r
);

  logic [3:0]   in_v;
  logic [N-1:0] in_d [4];

  assign in_v    = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign in_d[0] = i_a0_d;
  assign in_d[1] = i_a1_d;
  assign in_d[2] = i_a2_d;
  assign in_d[3] = i_a3_d;

  // Returns {found, index}: first valid input at offset 0..3 from the pointer.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic [1:0]   prio;
  logic         vld_p1;
  logic [N-1:0] data_p1;
  logic [1:0]   tag_p1;
  logic         load;
  logic         gnt_vld;
  logic [1:0]   gnt;
  logic         xfer;
  logic         upd_prio;
  logic [2:0]   rr;

  assign rr   = rr_pick(in_v, prio);
  assign load = !vld_p1 || i_z_r;

`ifdef CORY_RRMUX4_LAST_EN
  typedef enum logic {IDLE, LOCKED} lock_t;

  lock_t      state, state_nx;
  logic [1:0] lock_src, lock_src_nx;
  logic [3:0] in_l;
  logic       last_p1;

  assign in_l = {i_a3_l, i_a2_l, i_a1_l, i_a0_l};

  always_comb begin
    gnt         = rr[1:0];
    gnt_vld     = rr[2];
    state_nx    = state;
    lock_src_nx = lock_src;
    if (state == LOCKED) begin
      gnt     = lock_src;
      gnt_vld = in_v[lock_src];
    end
    xfer     = load && gnt_vld && !reset;
    upd_prio = xfer && in_l[gnt];
    if (xfer) begin
      if (in_l[gnt]) begin
        state_nx = IDLE;
      end else begin
        state_nx    = LOCKED;
        lock_src_nx = gnt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lock_src <= 2'd0;
      last_p1  <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_src <= lock_src_nx;
      if (xfer) last_p1 <= in_l[gnt];
    end
  end

  assign o_z_l = last_p1;
`else
  always_comb begin
    gnt      = rr[1:0];
    gnt_vld  = rr[2];
    xfer     = load && gnt_vld && !reset;
    upd_prio = xfer;
  end
`endif

  // Stage p1: output slot, loaded from the granted input, drained by i_z_r
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio    <= 2'd0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= 2'd0;
    end else begin
      if (upd_prio) prio <= gnt + 2'd1;
      if (xfer) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_d[gnt];
        tag_p1  <= gnt;
      end else if (i_z_r) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign o_a0_r = xfer && (gnt == 2'd0);
  assign o_a1_r = xfer && (gnt == 2'd1);
  assign o_a2_r = xfer && (gnt == 2'd2);
  assign o_a3_r = xfer && (gnt == 2'd3);

  assign o_z_v = vld_p1;
  assign o_z_d = data_p1;
  assign o_z_s = tag_p1;

endmodule
